dffram_access_ctrl: RTL and testbench
=====================================

Name: dffram_access_ctrl

Overview:
Sized-access front end that sits directly upstream of DFFRAM and drives its CLK/EN/WE[3:0]/A/Di port while consuming Do. It accepts one byte, halfword or word request at a time on a valid/ready interface, converts the byte address into DFFRAM word address plus byte-lane write mask, and returns lane-extracted read data on a valid/ready response channel. It replaces hand-built lane shifting in every DFFRAM client.

Parameters:
AW, 10, byte address width; DFFRAM word address is AW-2 bits (default 256 words)

Ports:
CLK  in  1  clock; DFFRAM shares it
RST  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at posedge
req_we  in  1  1 = write, 0 = read
req_size  in  2  0 byte, 1 halfword, 2 word, 3 illegal
req_signed  in  1  sign-extend byte/halfword read data
req_addr  in  AW  byte address
req_wdata  in  32  write data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at posedge
rsp_rdata  out  32  read data, right-aligned and extended; 0 for writes and errors
rsp_err  out  1  misaligned or illegal-size request
ram_EN  out  1  to DFFRAM EN
ram_WE  out  4  to DFFRAM WE
ram_A  out  AW-2  to DFFRAM A
ram_Di  out  32  to DFFRAM Di
ram_Do  in  32  from DFFRAM Do

Behaviour:
- Reset values: state IDLE; ram_EN=0, ram_WE=0, ram_A=0, ram_Di=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=0 while RST=1.
- All ram_* outputs are registered. ram_EN/ram_WE are nonzero only during ACC.
- FSM states: IDLE, ACC, WAIT, RSP. req_ready = (state==IDLE) & !RST.
- IDLE: on accept (cycle T), latch we, size, signed, addr[1:0].
  - Alignment check: halfword needs addr[0]=0; word needs addr[1:0]=0; size 3 is always an error.
  - Error -> RSP with rsp_err=1, rsp_rdata=0. No RAM access.
  - Otherwise -> ACC. Registered ram_A=addr[AW-1:2], ram_EN=1, ram_WE=mask (write) or 0 (read), ram_Di=lane data.
- Write mask/data:
  - byte: WE=1<<addr[1:0], Di={4{wdata[7:0]}}
  - halfword: WE=addr[1]?4'b1100:4'b0011, Di={2{wdata[15:0]}}
  - word: WE=4'b1111, Di=wdata
- ACC (T+1): DFFRAM performs the op at the closing edge.
  - Write -> RSP; rsp_valid=1 from T+2, rsp_rdata=0.
  - Read -> WAIT.
- WAIT (T+2): ram_Do is valid. Extract the lane and register it into rsp_rdata -> RSP; rsp_valid=1 from T+3.
  - byte: Do[8*a+:8]; halfword: Do[16*a[1]+:16]; word: Do.
  - Zero-extended unless signed=1, then sign-extended.
- RSP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On handshake, clear rsp_valid/rsp_err -> IDLE. Next accept is possible the following cycle.
- Latency with rsp_ready held high: write 2, read 3, error 1 cycles after accept. Throughput is one transaction in flight.
- Address wrap: none internal. The top word (byte addr 1020..1023) maps to A=255.
- Reset mid-operation: the FSM returns to IDLE and no response is issued. A write already driven in ACC completes in DFFRAM, because the outputs are registered.
- req_* are ignored outside IDLE. rsp_ready is ignored unless rsp_valid=1.

Decomposition:
- Package dffram_pkg:
  - size encodings SZ_BYTE=2'd0, SZ_HWORD=2'd1, SZ_WORD=2'd2
  - FSM state encoding IDLE/ACC/WAIT/RSP
  - alignment-check function
- Sub-module dffram_lane_mux: purely combinational write-mask/write-data generation and read lane extraction/extension, reused by future DFFRAM bus adapters.

Test Plan:
- Write word 0x88776655 at 0, then read word at 0 -> ram_WE=1111 in ACC, ram_A=0; rsp_rdata=0x88776655 at T+3.
- Write byte 0xAB at 1 -> ram_WE=0010, ram_Di=0xABABABAB. Read word 0 -> 0x8877AB55. Read signed byte 1 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Write word 0xEEEEEEEE at 4, hword 0xABCD at 6 -> WE=1100. Read word 4 -> 0xABCDEEEE. Read signed hword 6 -> 0xFFFFABCD.
- Hword at 3, word at 2, size=3 at 0 -> each gives rsp_err=1 one cycle after accept, rsp_rdata=0, ram_EN never asserted.
- Read at 1020 with rsp_ready low for 5 cycles -> ram_A=255. rsp_valid/rsp_rdata stable throughout, req_ready=0 until the handshake, then 1 the next cycle.
- RST pulsed during WAIT of a read -> no rsp_valid; all outputs 0 during reset; req_ready=1 the cycle after RST deasserts.

Source files
------------

// File: rtl/dffram_pkg.sv
// Shared definitions for DFFRAM front-end logic.
//   - access size encodings
//   - access controller FSM state type
//   - addr_ok(): natural-alignment / legal-size check for a sized access
package dffram_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HWORD = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  // 1 when a request of this size at this byte offset is legal and naturally aligned.
  function automatic logic addr_ok(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE:  ok = 1'b1;
      SZ_HWORD: ok = ~off[0];
      SZ_WORD:  ok = (off == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dffram_lane_mux.sv
// Combinational byte-lane steering for a 32-bit, 4-lane DFFRAM.
// Ports:
//   size       in   access size (dffram_pkg SZ_*)
//   off        in   byte offset within the word (addr[1:0])
//   sgn        in   sign-extend byte/halfword read data
//   wdata      in   right-aligned write data
//   rdata_raw  in   full word read from DFFRAM Do
//   we_mask    out  per-lane write enable (0 for illegal size)
//   wdata_lane out  write data replicated onto every candidate lane
//   rdata_ext  out  selected lane, right-aligned and zero/sign-extended
module dffram_lane_mux
  import dffram_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  we_mask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_hword;

  assign rd_byte  = rdata_raw[{off, 3'b000} +: 8];
  assign rd_hword = off[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    we_mask    = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rdata_raw;
    case (size)
      SZ_BYTE: begin
        we_mask    = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sgn & rd_byte[7]}}, rd_byte};
      end
      SZ_HWORD: begin
        we_mask    = off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sgn & rd_hword[15]}}, rd_hword};
      end
      SZ_WORD: begin
        we_mask    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
      end
      default: begin
        we_mask    = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dffram_access_ctrl.sv
// Sized-access front end for DFFRAM. Accepts one byte/halfword/word request at a time,
// drives registered EN/WE/A/Di to the RAM and returns lane-extracted read data.
// Ports:
//   CLK, RST           clock (shared with DFFRAM), synchronous active-high reset
//   req_valid/ready    request handshake; req_ready only in IDLE and not in reset
//   req_we/size/signed request kind, size, sign-extension of read data
//   req_addr           byte address
//   req_wdata          right-aligned write data
//   rsp_valid/ready    response handshake
//   rsp_rdata          read data (0 for writes and errors)
//   rsp_err            misaligned or illegal-size request
//   ram_EN/WE/A/Di     registered DFFRAM controls
//   ram_Do             DFFRAM read data, valid one cycle after the access edge
module dffram_access_ctrl
  import dffram_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_EN,
  output logic [3:0]    ram_WE,
  output logic [AW-3:0] ram_A,
  output logic [31:0]   ram_Di,
  input  logic [31:0]   ram_Do
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;

  logic          ram_en_q, ram_en_d;
  logic [3:0]    ram_we_q, ram_we_d;
  logic [AW-3:0] ram_a_q, ram_a_d;
  logic [31:0]   ram_di_q, ram_di_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic [1:0]  lm_size, lm_off;
  logic [3:0]  lm_we_mask;
  logic [31:0] lm_wdata, lm_rdata;

  // In IDLE the mux steers the incoming request; afterwards it extracts using latched fields.
  assign lm_size = (state_q == IDLE) ? req_size      : size_q;
  assign lm_off  = (state_q == IDLE) ? req_addr[1:0] : off_q;

  dffram_lane_mux u_lane_mux (
    .size      (lm_size),
    .off       (lm_off),
    .sgn       (sgn_q),
    .wdata     (req_wdata),
    .rdata_raw (ram_Do),
    .we_mask   (lm_we_mask),
    .wdata_lane(lm_wdata),
    .rdata_ext (lm_rdata)
  );

  assign req_ready = (state_q == IDLE) & ~RST;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_a_d     = ram_a_q;
    ram_di_d    = ram_di_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          sgn_d  = req_signed;
          off_d  = req_addr[1:0];
          if (!addr_ok(req_size, req_addr[1:0])) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d  = ACC;
            ram_en_d = 1'b1;
            ram_we_d = req_we ? lm_we_mask : 4'b0000;
            ram_a_d  = req_addr[AW-1:2];
            ram_di_d = lm_wdata;
          end
        end
      end
      ACC: begin
        if (we_q) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = lm_rdata;
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      off_q       <= 2'b00;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_a_q     <= '0;
      ram_di_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_a_q     <= ram_a_d;
      ram_di_q    <= ram_di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_EN    = ram_en_q;
  assign ram_WE    = ram_we_q;
  assign ram_A     = ram_a_q;
  assign ram_Di    = ram_di_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dffram_access_ctrl.sv
module tb_dffram_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_EN;
  logic [3:0]  ram_WE;
  logic [7:0]  ram_A;
  logic [31:0] ram_Di, ram_Do;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];   // {err, rdata}
  logic [31:0] mem[256];
  logic [31:0] shadow[256];

  always #5 CLK = ~CLK;

  dffram_access_ctrl #(.AW(10)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_EN    (ram_EN),
    .ram_WE    (ram_WE),
    .ram_A     (ram_A),
    .ram_Di    (ram_Di),
    .ram_Do    (ram_Do)
  );

  // DFFRAM behavioural model: registered Do, per-lane write enables.
  always @(posedge CLK) begin
    if (ram_EN) begin
      for (int i = 0; i < 4; i++)
        if (ram_WE[i]) mem[ram_A][8*i +: 8] <= ram_Di[8*i +: 8];
      ram_Do <= mem[ram_A];
    end
  end

  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input logic [3:0] exp_we, input logic [31:0] exp_di, input string name);
    int cyc;
    int exp_lat;
    logic [32:0] e;
    exp_lat = exp_err ? 1 : (we ? 2 : 3);
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge CLK); cyc++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL %s accept: req_ready=%b want 1", name, req_ready); end
    @(negedge CLK);
    req_valid = 1'b0;
    cyc = 1;
    checks++;
    if (exp_err) begin
      if (ram_EN !== 1'b0 || ram_WE !== 4'b0) begin
        errors++; $display("FAIL %s ram_idle: EN=%b WE=%b want 0 0", name, ram_EN, ram_WE);
      end
    end else if (ram_EN !== 1'b1 || ram_WE !== exp_we || ram_A !== addr[9:2]) begin
      errors++;
      $display("FAIL %s acc: EN=%b WE=%b A=%0d want 1 %b %0d", name, ram_EN, ram_WE, ram_A,
               exp_we, addr[9:2]);
    end
    if (!exp_err && we) begin
      checks++;
      if (ram_Di !== exp_di) begin
        errors++; $display("FAIL %s di: got %h want %h", name, ram_Di, exp_di);
      end
    end
    while (!rsp_valid && cyc < 20) begin @(negedge CLK); cyc++; end
    checks++;
    if (cyc !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== e[32] || rsp_rdata !== e[31:0]) begin
      errors++;
      $display("FAIL %s rsp: valid=%b err=%b rdata=%h want 1 %b %h", name, rsp_valid, rsp_err,
               rsp_rdata, e[32], e[31:0]);
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_hs: rsp_valid=%b req_ready=%b want 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ram_EN, ram_WE, ram_A, ram_Di, rsp_valid, rsp_err, rsp_rdata, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: EN=%b WE=%b A=%h Di=%h v=%b e=%b rd=%h rdy=%b want all 0",
               ram_EN, ram_WE, ram_A, ram_Di, rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    xact(1, 2'd2, 0, 10'd0, 32'h88776655, 32'h0, 0, 4'b1111, 32'h88776655, "wr_word0");
    xact(0, 2'd2, 0, 10'd0, 32'h0, 32'h88776655, 0, 4'b0000, 32'h0, "rd_word0");
  endtask

  task automatic test_byte();
    xact(1, 2'd0, 0, 10'd1, 32'h000000AB, 32'h0, 0, 4'b0010, 32'hABABABAB, "wr_byte1");
    xact(0, 2'd2, 0, 10'd0, 32'h0, 32'h8877AB55, 0, 4'b0000, 32'h0, "rd_word0b");
    xact(0, 2'd0, 1, 10'd1, 32'h0, 32'hFFFFFFAB, 0, 4'b0000, 32'h0, "rd_sbyte1");
    xact(0, 2'd0, 0, 10'd1, 32'h0, 32'h000000AB, 0, 4'b0000, 32'h0, "rd_ubyte1");
  endtask

  task automatic test_hword();
    xact(1, 2'd2, 0, 10'd4, 32'hEEEEEEEE, 32'h0, 0, 4'b1111, 32'hEEEEEEEE, "wr_word4");
    xact(1, 2'd1, 0, 10'd6, 32'h0000ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD, "wr_hword6");
    xact(0, 2'd2, 0, 10'd4, 32'h0, 32'hABCDEEEE, 0, 4'b0000, 32'h0, "rd_word4");
    xact(0, 2'd1, 1, 10'd6, 32'h0, 32'hFFFFABCD, 0, 4'b0000, 32'h0, "rd_shword6");
  endtask

  task automatic test_errors();
    xact(0, 2'd1, 0, 10'd3, 32'h0, 32'h0, 1, 4'b0000, 32'h0, "err_hword3");
    xact(1, 2'd2, 0, 10'd2, 32'h12345678, 32'h0, 1, 4'b0000, 32'h0, "err_word2");
    xact(0, 2'd3, 0, 10'd0, 32'h0, 32'h0, 1, 4'b0000, 32'h0, "err_size3");
    // A rejected write must not have disturbed word 0.
    xact(0, 2'd2, 0, 10'd0, 32'h0, 32'h8877AB55, 0, 4'b0000, 32'h0, "rd_word0_after_err");
  endtask

  task automatic test_stall();
    int cyc;
    xact(1, 2'd2, 0, 10'd1020, 32'h13579BDF, 32'h0, 0, 4'b1111, 32'h13579BDF, "wr_top");
    rsp_ready = 1'b0;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 10'd1020;
    exp_q.push_back({1'b0, 32'h13579BDF});
    @(negedge CLK);
    req_valid = 1'b0;
    checks++;
    if (ram_EN !== 1'b1 || ram_A !== 8'd255) begin
      errors++; $display("FAIL stall_addr: EN=%b A=%0d want 1 255", ram_EN, ram_A);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin @(negedge CLK); cyc++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_q[0][31:0] || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: v=%b rd=%h rdy=%b want 1 %h 0", i, rsp_valid, rsp_rdata,
                 req_ready, exp_q[0][31:0]);
      end
      @(negedge CLK);
    end
    void'(exp_q.pop_front());
    rsp_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: v=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 10'd0;
    @(negedge CLK);   // ACC
    req_valid = 1'b0;
    @(negedge CLK);   // WAIT
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ram_EN, ram_WE, ram_A, ram_Di, rsp_valid, rsp_err, rsp_rdata, req_ready} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: EN=%b WE=%b A=%h Di=%h v=%b e=%b rd=%h rdy=%b want all 0",
               ram_EN, ram_WE, ram_A, ram_Di, rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: rdy=%b v=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  a;
    logic [1:0]  sz;
    logic        we, sgn, err;
    logic [31:0] wd, w, sh, exp_rd, di;
    logic [3:0]  msk;
    for (int i = 16; i < 24; i++) begin
      wd = $urandom;
      shadow[i] = wd;
      xact(1, 2'd2, 0, 10'(i * 4), wd, 32'h0, 0, 4'b1111, wd, "seed_word");
    end
    for (int n = 0; n < 30; n++) begin
      a   = 10'($urandom_range(64, 95));
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      wd  = $urandom;
      err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      w   = shadow[a[9:2]];
      exp_rd = 32'h0; msk = 4'b0000; di = 32'h0;
      if (!err && !we) begin
        if (sz == 2'd0) begin
          sh = w >> (8 * a[1:0]);
          exp_rd = {{24{sh[7] & sgn}}, sh[7:0]};
        end else if (sz == 2'd1) begin
          sh = w >> (16 * a[1]);
          exp_rd = {{16{sh[15] & sgn}}, sh[15:0]};
        end else exp_rd = w;
      end
      if (!err && we) begin
        if (sz == 2'd0) begin
          msk = 4'b0001 << a[1:0]; di = {4{wd[7:0]}}; w[8*a[1:0] +: 8] = wd[7:0];
        end else if (sz == 2'd1) begin
          msk = a[1] ? 4'b1100 : 4'b0011; di = {2{wd[15:0]}}; w[16*a[1] +: 16] = wd[15:0];
        end else begin
          msk = 4'b1111; di = wd; w = wd;
        end
        shadow[a[9:2]] = w;
      end
      xact(we, sz, sgn, a, wd, exp_rd, err, msk, di, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_hword();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
